// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data cache memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 128;

    // Byte-offset bits cleared to align an address to a 16-byte line or a 4-byte word
    localparam logic [3:0] LINE_OFS_MASK = 4'hF;
    localparam logic [3:0] WORD_OFS_MASK = 4'h3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IC_RD = 3'd1,
        DC_RD = 3'd2,
        DC_WR = 3'd3,
        DONE  = 3'd4
    } state_e;

    typedef enum logic {
        GNT_IC = 1'b0,
        GNT_DC = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick between the I-cache and D-cache with its last-grant history.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic en_i,
    input  logic req_ic_i,
    input  logic req_dc_i,
    output logic gnt_ic_o,
    output logic gnt_dc_o
);

    owner_e last_q;
    owner_e last_d;

    // On a tie the side that did not win last time gets the grant
    always_comb begin
        gnt_ic_o = req_ic_i && (!req_dc_i || (last_q == GNT_DC));
        gnt_dc_o = req_dc_i && !gnt_ic_o;
        last_d   = last_q;
        if (en_i && gnt_ic_o) begin
            last_d = GNT_IC;
        end else if (en_i && gnt_dc_o) begin
            last_d = GNT_DC;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q <= GNT_DC;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache line fills and D-cache fills/word writes onto one RAM port,
// one transaction per grant, with a bounded wait for mem_ready.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic              dc_rd_req,
    input  logic              dc_wr_req,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [31:0]       dc_wdata,
    output logic              ic_done,
    output logic              dc_done,
    output logic              err,
    output logic [LINE_W-1:0] rdata_line,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_OFS_MASK);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(WORD_OFS_MASK);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                grant_en;
    logic                gnt_ic, gnt_dc;

    assign grant_en = (state_q == IDLE);

    rr_arb2 u_rr (
        .clk      (clk),
        .rstn     (rstn),
        .en_i     (grant_en),
        .req_ic_i (ic_req),
        .req_dc_i (dc_rd_req | dc_wr_req),
        .gnt_ic_o (gnt_ic),
        .gnt_dc_o (gnt_dc)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                err_d = 1'b0;
                if (gnt_ic) begin
                    state_d = IC_RD;
                    owner_d = GNT_IC;
                    addr_d  = ic_addr;
                end else if (gnt_dc) begin
                    // A pending write goes first; a simultaneous read waits for the next grant
                    state_d = dc_wr_req ? DC_WR : DC_RD;
                    owner_d = GNT_DC;
                    addr_d  = dc_addr;
                    if (dc_wr_req) begin
                        wdata_d = dc_wdata;
                    end
                end
            end
            IC_RD, DC_RD, DC_WR: begin
                if (mem_ready) begin
                    state_d = DONE;
                    if (state_q != DC_WR) begin
                        rdata_d = mem_rdata;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            owner_q <= GNT_DC;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        mem_rd     = (state_q == IC_RD) || (state_q == DC_RD);
        mem_wr     = (state_q == DC_WR);
        mem_addr   = '0;
        mem_wdata  = '0;
        if (mem_rd) begin
            mem_addr = addr_q & LINE_MASK;
        end else if (mem_wr) begin
            mem_addr  = addr_q & WORD_MASK;
            mem_wdata = wdata_q;
        end
        ic_done    = (state_q == DONE) && (owner_q == GNT_IC);
        dc_done    = (state_q == DONE) && (owner_q == GNT_DC);
        err        = (state_q == DONE) && err_q;
        rdata_line = rdata_q;
    end

endmodule
